// File: rtl/ov7670_config_sequencer.sv
// ============================================================================
//  Module      : ov7670_config_sequencer
//  Description : Walks an init ROM of {reg_addr, reg_value} pairs and issues
//                one SCCB write per entry, honouring end/delay markers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ov7670_config_sequencer #(
    parameter int CLK_FREQ = 25000000,
    parameter int DELAY_MS = 10,
    parameter int ROM_AW   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              done,
    output logic              busy,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              sccb_start,
    output logic [7:0]        sccb_address,
    output logic [7:0]        sccb_data,
    input  logic              sccb_ready
);

    localparam logic [31:0] c_delay_cycles = 32'(CLK_FREQ / 1000 * DELAY_MS);
    localparam logic [15:0] c_mark_end     = 16'hFFFF;
    localparam logic [15:0] c_mark_delay   = 16'hFFF0;

    localparam logic [3:0] c_st_idle   = 4'd0;
    localparam logic [3:0] c_st_fetch  = 4'd1;
    localparam logic [3:0] c_st_decode = 4'd2;
    localparam logic [3:0] c_st_issue  = 4'd3;
    localparam logic [3:0] c_st_ack    = 4'd4;
    localparam logic [3:0] c_st_wait   = 4'd5;
    localparam logic [3:0] c_st_delay  = 4'd6;
    localparam logic [3:0] c_st_next   = 4'd7;
    localparam logic [3:0] c_st_done   = 4'd8;

    logic [3:0]        r_state;
    logic [31:0]       r_delay_cnt;

    logic [3:0]        w_state_nxt;
    logic [31:0]       w_delay_cnt_nxt;
    logic              w_done_nxt;
    logic              w_busy_nxt;
    logic [ROM_AW-1:0] w_rom_addr_nxt;
    logic              w_sccb_start_nxt;
    logic [7:0]        w_sccb_address_nxt;
    logic [7:0]        w_sccb_data_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_delay_cnt  <= 32'd0;
            done         <= 1'b0;
            busy         <= 1'b0;
            rom_addr     <= '0;
            sccb_start   <= 1'b0;
            sccb_address <= 8'd0;
            sccb_data    <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_delay_cnt  <= w_delay_cnt_nxt;
            done         <= w_done_nxt;
            busy         <= w_busy_nxt;
            rom_addr     <= w_rom_addr_nxt;
            sccb_start   <= w_sccb_start_nxt;
            sccb_address <= w_sccb_address_nxt;
            sccb_data    <= w_sccb_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_delay_cnt_nxt    = r_delay_cnt;
        w_done_nxt         = done;
        w_busy_nxt         = busy;
        w_rom_addr_nxt     = rom_addr;
        w_sccb_start_nxt   = 1'b0;
        w_sccb_address_nxt = sccb_address;
        w_sccb_data_nxt    = sccb_data;

        case (r_state)
            c_st_idle, c_st_done: begin
                if (start) begin
                    w_busy_nxt     = 1'b1;
                    w_done_nxt     = 1'b0;
                    w_rom_addr_nxt = '0;
                    w_state_nxt    = c_st_fetch;
                end
            end
            c_st_fetch: w_state_nxt = c_st_decode;
            c_st_decode: begin
                if (rom_data == c_mark_end) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = c_st_done;
                end else if (rom_data == c_mark_delay) begin
                    w_delay_cnt_nxt = c_delay_cycles;
                    w_state_nxt     = c_st_delay;
                end else begin
                    w_sccb_address_nxt = rom_data[15:8];
                    w_sccb_data_nxt    = rom_data[7:0];
                    w_state_nxt        = c_st_issue;
                end
            end
            // Waiting for ready here also keeps us off a frame left running across a reset.
            c_st_issue: begin
                if (sccb_ready) begin
                    w_sccb_start_nxt = 1'b1;
                    w_state_nxt      = c_st_ack;
                end
            end
            c_st_ack: if (!sccb_ready) w_state_nxt = c_st_wait;
            c_st_wait: if (sccb_ready) w_state_nxt = c_st_next;
            c_st_delay: begin
                if (r_delay_cnt == 32'd0) w_state_nxt = c_st_next;
                else w_delay_cnt_nxt = r_delay_cnt - 32'd1;
            end
            c_st_next: begin
                if (&rom_addr) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = c_st_done;
                end else begin
                    w_rom_addr_nxt = rom_addr + ROM_AW'(1);
                    w_state_nxt    = c_st_fetch;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_ov7670_config_sequencer.sv
// ============================================================================
//  Module      : tb_ov7670_config_sequencer
//  Description : Directed bench with ROM and SCCB engine models for the
//                config sequencer (main table instance plus a 4-entry instance).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ov7670_config_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        done;
    logic        busy;
    logic [7:0]  rom_addr;
    logic [15:0] rom_q;
    logic        sccb_start;
    logic [7:0]  sccb_address;
    logic [7:0]  sccb_data;
    logic        ready;

    logic        start2;
    logic        done2;
    logic        busy2;
    logic [1:0]  rom_addr2;
    logic [15:0] rom_q2;
    logic        sccb_start2;
    logic [7:0]  sccb_address2;
    logic [7:0]  sccb_data2;
    logic        ready2;

    logic [15:0] rom_mem [0:255];
    logic        eng_rst;
    logic        log_clr;
    int          eng_lat;
    int          eng_cnt;
    int          eng_cnt2;
    logic [7:0]  n_wr;
    logic [7:0]  n_wr2;
    logic [7:0]  viol;
    logic [7:0]  log_addr [0:15];
    logic [7:0]  log_data [0:15];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc;

    always #5 clk = ~clk;

    ov7670_config_sequencer #(.CLK_FREQ(1000000), .DELAY_MS(1), .ROM_AW(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .done(done), .busy(busy),
        .rom_addr(rom_addr), .rom_data(rom_q), .sccb_start(sccb_start),
        .sccb_address(sccb_address), .sccb_data(sccb_data), .sccb_ready(ready)
    );

    ov7670_config_sequencer #(.CLK_FREQ(1000000), .DELAY_MS(1), .ROM_AW(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .done(done2), .busy(busy2),
        .rom_addr(rom_addr2), .rom_data(rom_q2), .sccb_start(sccb_start2),
        .sccb_address(sccb_address2), .sccb_data(sccb_data2), .sccb_ready(ready2)
    );

    always @(posedge clk) rom_q <= rom_mem[rom_addr];
    always @(posedge clk) rom_q2 <= (rom_addr2 <= 2'd3) ? 16'h0102 : 16'hFFFF;

    // Engine: ready drops the cycle after an accepted start, returns after eng_lat cycles.
    always @(posedge clk) begin
        if (eng_rst) begin
            ready   <= 1'b1;
            eng_cnt <= 0;
            n_wr    <= 8'd0;
            viol    <= 8'd0;
        end else begin
            if (log_clr) n_wr <= 8'd0;
            if (sccb_start && !ready) viol <= viol + 8'd1;
            if (sccb_start && ready) begin
                ready                <= 1'b0;
                eng_cnt              <= eng_lat;
                log_addr[n_wr[3:0]]  <= sccb_address;
                log_data[n_wr[3:0]]  <= sccb_data;
                n_wr                 <= n_wr + 8'd1;
            end else if (!ready) begin
                if (eng_cnt == 0) ready <= 1'b1;
                else eng_cnt <= eng_cnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (eng_rst) begin
            ready2   <= 1'b1;
            eng_cnt2 <= 0;
            n_wr2    <= 8'd0;
        end else if (sccb_start2 && ready2 && sccb_address2 == 8'h01 && sccb_data2 == 8'h02) begin
            ready2   <= 1'b0;
            eng_cnt2 <= 3;
            n_wr2    <= n_wr2 + 8'd1;
        end else if (!ready2) begin
            if (eng_cnt2 == 0) ready2 <= 1'b1;
            else eng_cnt2 <= eng_cnt2 - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_log();
        log_clr = 1'b1;
        tick();
        log_clr = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        for (int i = 0; i < bound && !done; i++) tick();
        check(tag, done, 1);
    endtask

    task automatic load3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        for (int i = 0; i < 256; i++) rom_mem[i] = 16'hFFFF;
        rom_mem[0] = a;
        rom_mem[1] = b;
        rom_mem[2] = c;
    endtask

    // Counts edges from the start-sampling edge up to the first visible sccb_start.
    task automatic time_first_write(input int bound);
        cyc = 1;
        while (!sccb_start && cyc < bound) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        eng_rst = 1'b1; log_clr = 1'b0; eng_lat = 5;
        load3(16'hFFFF, 16'hFFFF, 16'hFFFF);
        repeat (3) tick();
        eng_rst = 1'b0;
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_sccb_start", sccb_start, 0);
        check("rst_sccb_addr", sccb_address, 0);
        check("rst_sccb_data", sccb_data, 0);
        rst = 1'b0;
        tick();

        // Two plain writes
        load3(16'h1280, 16'h1101, 16'hFFFF);
        clear_log();
        pulse_start();
        check("t1_busy", busy, 1);
        time_first_write(20);
        check("t1_latency", cyc, 4);
        wait_done("t1_done", 200);
        check("t1_busy_end", busy, 0);
        check("t1_nwr", n_wr, 2);
        check("t1_addr0", log_addr[0], 8'h12);
        check("t1_data0", log_data[0], 8'h80);
        check("t1_addr1", log_addr[1], 8'h11);
        check("t1_data1", log_data[1], 8'h01);

        // Empty table
        load3(16'hFFFF, 16'h1280, 16'hFFFF);
        clear_log();
        pulse_start();
        check("t3_done_lo", done, 0);
        tick();
        tick();
        check("t3_done", done, 1);
        check("t3_busy", busy, 0);
        repeat (5) tick();
        check("t3_nwr", n_wr, 0);

        // Delay marker: 1000 cycles at 1 MHz / 1 ms
        load3(16'hFFF0, 16'h3A04, 16'hFFFF);
        clear_log();
        pulse_start();
        time_first_write(3000);
        check("t2_delay_range", (cyc >= 1000 && cyc < 1100), 1);
        wait_done("t2_done", 200);
        check("t2_nwr", n_wr, 1);
        check("t2_addr", log_addr[0], 8'h3A);
        check("t2_data", log_data[0], 8'h04);

        // Two consecutive delay markers
        load3(16'hFFF0, 16'hFFF0, 16'h3A04);
        clear_log();
        pulse_start();
        time_first_write(4000);
        check("t2b_delay_range", (cyc >= 2000 && cyc < 2100), 1);
        wait_done("t2b_done", 200);
        check("t2b_nwr", n_wr, 1);

        // Full 4-entry table, no end marker
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 300 && !done2; i++) tick();
        check("t4_done", done2, 1);
        check("t4_nwr", n_wr2, 4);
        check("t4_rom_addr", rom_addr2, 3);
        check("t4_busy", busy2, 0);

        // Reset while the engine is mid-frame
        load3(16'h1280, 16'h1101, 16'hFFFF);
        eng_lat = 40;
        clear_log();
        pulse_start();
        for (int i = 0; i < 20 && ready; i++) tick();
        check("t5_engine_busy", ready, 0);
        rst = 1'b1;
        tick();
        check("t5_rst_busy", busy, 0);
        check("t5_rst_rom_addr", rom_addr, 0);
        check("t5_rst_sccb_start", sccb_start, 0);
        rst = 1'b0;
        clear_log();
        pulse_start();
        time_first_write(200);
        check("t5_held_off", (cyc > 4), 1);
        check("t5_ready_at_start", ready, 1);
        wait_done("t5_done", 400);
        check("t5_nwr", n_wr, 2);
        check("t5_addr0", log_addr[0], 8'h12);
        check("t5_addr1", log_addr[1], 8'h11);
        eng_lat = 5;

        // Start while busy is ignored; start in DONE replays
        load3(16'h1280, 16'h1101, 16'h1302);
        rom_mem[3] = 16'hFFFF;
        clear_log();
        pulse_start();
        for (int i = 0; i < 50 && n_wr == 0; i++) tick();
        pulse_start();
        check("t6_busy_mid", busy, 1);
        wait_done("t6_done", 300);
        check("t6_nwr", n_wr, 3);
        check("t6_addr0", log_addr[0], 8'h12);
        check("t6_addr1", log_addr[1], 8'h11);
        check("t6_addr2", log_addr[2], 8'h13);
        clear_log();
        pulse_start();
        check("t6_restart_busy", busy, 1);
        check("t6_restart_done", done, 0);
        wait_done("t6_done2", 300);
        check("t6_nwr2", n_wr, 3);
        check("t6_addr2b", log_addr[2], 8'h13);
        check("t6_data2b", log_data[2], 8'h02);

        check("no_start_when_busy", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
